// File: rtl/niox_bus_pkg.sv
// Shared definitions for the niox two-master bus arbiter.
package niox_bus_pkg;

    localparam int unsigned AW_DEF = 22;
    localparam int unsigned DW_DEF = 32;

    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        REL  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/niox_rr_pick2.sv
// Two-way round-robin selector: on a tie the master that did not own the bus last wins.
module niox_rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic owner,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = req0 | req1;
    assign gnt_idx   = (req0 & req1) ? ~owner : req1;

endmodule

// File: rtl/niox_bus_arb.sv
// Two-master round-robin arbiter in front of busint; one outstanding transfer at a time.
// Optional grant timeout with sticky error flag: define NIOX_BUS_ARB_TIMEOUT_EN.
module niox_bus_arb
    import niox_bus_pkg::*;
#(
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          bus_req,
    output logic          bus_write,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          owner,
    output logic          busy,
    output logic          to_err
);

    arb_state_t    state;
    logic          gnt_valid;
    logic          gnt_idx;
    logic          granted;
    logic          sel1;
    logic          expire;
    logic          done;
    logic [DW-1:0] rsp_data;

    niox_rr_pick2 u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .owner     (owner),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign granted = (state == GNT0) || (state == GNT1);
    assign sel1    = (state == GNT1);

`ifdef NIOX_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] to_cnt;
    logic          to_err_q;

    // A real ack in the expiry cycle wins over the timeout.
    assign expire   = granted && !bus_ack && (to_cnt == CW'(TIMEOUT_CYC - 1));
    assign rsp_data = expire ? DW'(TO_DATA) : bus_rdata;
    assign to_err   = to_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if (granted && !bus_ack) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (expire) begin
                to_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign rsp_data   = bus_rdata;
    assign to_err     = 1'b0;
    assign unused_cfg = ^32'(TIMEOUT_CYC);
`endif

    assign done = bus_ack | expire;

    // Grant FSM; owner records the most recent grant for tie-breaking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state <= gnt_idx ? GNT1 : GNT0;
                        owner <= gnt_idx;
                    end
                end
                GNT0, GNT1: begin
                    if (done) begin
                        state <= REL;
                    end
                end
                REL:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign bus_req   = granted & ~expire;
    assign bus_write = granted & (sel1 ? m1_write : m0_write);
    assign bus_addr  = granted ? (sel1 ? m1_addr : m0_addr) : '0;
    assign bus_wdata = granted ? (sel1 ? m1_wdata : m0_wdata) : '0;

    // A master that has already dropped req gets no ack; the transfer completes silently.
    assign m0_ack   = (state == GNT0) & m0_req & done;
    assign m1_ack   = (state == GNT1) & m1_req & done;
    assign m0_rdata = (state == GNT0) ? rsp_data : '0;
    assign m1_rdata = (state == GNT1) ? rsp_data : '0;

endmodule

// File: tb/tb_niox_bus_arb.sv
// Scoreboard bench for niox_bus_arb with a simple busint slave model.
module tb_niox_bus_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [21:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        bus_req, bus_write, bus_ack;
    logic [21:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        owner, busy, to_err;

    typedef struct {
        bit          m;
        bit          wr;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    int   slave_dly = 2;
    int   slave_cyc = 0;
    logic slave_ack = 1'b0;
    logic spur_ack  = 1'b0;

    always #5 clk = ~clk;

    niox_bus_arb #(.AW(22), .DW(32), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_write  (m0_write),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_write  (m1_write),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .bus_req   (bus_req),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .owner     (owner),
        .busy      (busy),
        .to_err    (to_err)
    );

    function automatic logic [31:0] rd_model(input logic [21:0] a);
        return 32'h1234_5678 ^ {10'd0, a ^ 22'h000100};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: acks slave_dly cycles after bus_req first rises.
    assign bus_ack   = slave_ack | spur_ack;
    assign bus_rdata = slave_ack ? rd_model(bus_addr) : 32'h0;

    always @(negedge clk) begin
        if (bus_req && !bus_ack) slave_cyc <= slave_cyc + 1;
        else                     slave_cyc <= 0;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            slave_ack = (slave_cyc == slave_dly);
        end
    end

    // Monitor: compares every granted cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus_req) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q[0];
                    check("bus_owner", 64'(owner), 64'(mon_e.m));
                    check("bus_addr",  64'(bus_addr), 64'(mon_e.addr));
                    check("bus_write", 64'(bus_write), 64'(mon_e.wr));
                    check("bus_wdata", 64'(bus_wdata), 64'(mon_e.wdata));
                    check("acks", 64'({m1_ack, m0_ack}),
                          bus_ack ? (mon_e.m ? 64'd2 : 64'd1) : 64'd0);
                    if (bus_ack) begin
                        if (!mon_e.wr)
                            check("rdata", 64'(mon_e.m ? m1_rdata : m0_rdata), 64'(mon_e.rd));
                        check("rdata_other", 64'(mon_e.m ? m0_rdata : m1_rdata), 64'd0);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_bus", 64'({m1_ack, m0_ack, bus_write, bus_addr, bus_wdata}), 64'd0);
            end
        end
    end

    function automatic void exp_push(input bit m, input bit wr, input logic [21:0] a,
                                     input logic [31:0] d);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = a; e.wdata = d; e.rd = rd_model(a);
        exp_q.push_back(e);
    endfunction

    task automatic do_xfer(input bit m, input bit wr, input logic [21:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        if (!m) begin
            m0_req = 1'b1; m0_write = wr; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1'b1; m1_write = wr; m1_addr = a; m1_wdata = d;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = m ? m1_ack : m0_ack;
        end
        if (!got) check(m ? "m1_ack_wait" : "m0_ack_wait", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!m) begin m0_req = 1'b0; m0_write = 1'b0; end
        else    begin m1_req = 1'b0; m1_write = 1'b0; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] a0 [3];
        logic [21:0] a1 [3];
        logic [31:0] d1 [3];
        reset = 1'b1;
        m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'({bus_req, busy, to_err, m0_ack, m1_ack, owner}), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Single m0 read with latency checks.
        exp_push(0, 0, 22'h000100, 32'h0);
        fork
            do_xfer(0, 0, 22'h000100, 32'h0);
            begin
                @(negedge clk);
                check("lat_k", 64'(bus_req), 64'd0);
                @(negedge clk);
                check("lat_k1", 64'(bus_req), 64'd1);
            end
        join

        // In REL now; spurious acks in REL and IDLE.
        spur_ack = 1'b1;
        @(negedge clk);
        check("rel", 64'({bus_req, busy, m0_ack, m1_ack}), 64'b0100);
        @(posedge clk); #1;
        @(negedge clk);
        check("spur_idle", 64'({busy, m0_ack, m1_ack}), 64'd0);
        @(posedge clk); #1;
        spur_ack = 1'b0;
        exp_push(1, 0, 22'h3FFFFF, 32'h0);
        do_xfer(1, 0, 22'h3FFFFF, 32'h0);
        @(posedge clk); #1;

        // Reset while GNT1 has an ack pending.
        mon_en = 1'b0;
        slave_dly = 4;
        m1_req = 1'b1; m1_write = 1'b1; m1_addr = 22'h00002A; m1_wdata = 32'h0000_1111;
        @(negedge clk);
        @(negedge clk);
        check("gnt1", 64'({bus_req, owner}), 64'b11);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("pre_rst_ack", 64'(m1_ack), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; m1_req = 1'b0; m1_write = 1'b0;
        @(negedge clk);
        check("post_rst", 64'({bus_req, busy, owner, m1_ack}), 64'b0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_late_ack", 64'({m1_ack, bus_req}), 64'd0);
        end
        @(posedge clk); #1;
        slave_dly = 2;
        mon_en = 1'b1;

        // Simultaneous requests after reset: m0 first.
        exp_push(0, 0, 22'h000200, 32'h0);
        exp_push(1, 1, 22'h000300, 32'hCAFE_0001);
        fork
            do_xfer(0, 0, 22'h000200, 32'h0);
            do_xfer(1, 1, 22'h000300, 32'hCAFE_0001);
        join
        @(posedge clk); #1;

        // Continuous requests from both: strict alternation.
        for (int k = 0; k < 3; k++) begin
            a0[k] = 22'(22'h001000 + k);
            a1[k] = 22'(22'h002000 + k);
            d1[k] = $urandom;
        end
        for (int k = 0; k < 3; k++) begin
            exp_push(0, 0, a0[k], 32'h0);
            exp_push(1, 1, a1[k], d1[k]);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    do_xfer(0, 0, a0[k], 32'h0);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    do_xfer(1, 1, a1[k], d1[k]);
                    @(posedge clk); #1;
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

`ifdef NIOX_BUS_ARB_TIMEOUT_EN
        // Timeout without ack, then ack arriving in the expiry cycle.
        mon_en = 1'b0;
        for (int v = 0; v < 2; v++) begin
            int   n;
            logic got;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("to_err_rst", 64'(to_err), 64'd0);
            @(posedge clk); #1;
            slave_dly = (v != 0) ? 15 : 1000;
            m0_req = 1'b1; m0_write = 1'b0; m0_addr = 22'h000055;
            n = 0; got = 1'b0;
            while (!got && n < 60) begin
                @(negedge clk);
                n++;
                got = m0_ack;
            end
            check("to_cyc", 64'(n), 64'd17);
            check("to_busreq", 64'(bus_req), 64'(v));
            check("to_rdata", 64'(m0_rdata), (v != 0) ? 64'(rd_model(22'h000055)) : 64'hDEAD_BEEF);
            @(posedge clk); #1;
            m0_req = 1'b0;
            @(negedge clk);
            check("to_err", 64'(to_err), (v != 0) ? 64'd0 : 64'd1);
            repeat (5) @(negedge clk);
            check("to_err_sticky", 64'(to_err), (v != 0) ? 64'd0 : 64'd1);
            @(posedge clk); #1;
        end
        slave_dly = 2;
`endif

        check("sb_left", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
